muldiv_iter: RTL and testbench
==============================

Name: muldiv_iter

Overview:
- Iterative RV32M multiply/divide unit for the multi-cycle CPU's execute step.
- Operands come from the RD1/RD2 holding registers (A, B); its result feeds the ALUOut holding register through the result mux.
- The control FSM issues start and stalls in an execute-wait state until done pulses.
- Radix-2, one bit per cycle, with a fast path for divide-by-zero and signed overflow.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- ID, 3'b100, instance tag printed by the trace feature.

Ports:
- clk  input  1  clock; all state changes on posedge clk.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk.
- start  input  1  request; accepted only when busy=0.
- op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  WIDTH  rs1 operand; sampled only on the accept edge.
- b  input  WIDTH  rs2 operand; sampled only on the accept edge.
- busy  output  1  high from the accept edge until the edge that leaves DONE.
- done  output  1  one-cycle pulse; result is valid in the same cycle.
- result  output  WIDTH  registered result; held until the next accept or reset.

Behaviour:
- Reset (reset=0 at posedge):
  - state=IDLE, busy=0, done=0, result=0, counter=0.
  - Reset aborts any operation in flight; no done pulse is produced for it.
- States: IDLE, CALC, DONE.
- IDLE:
  - If start=1, latch op, a, b, and the sign flags; busy goes 1.
  - Fast path (division ops only) goes straight to DONE.
  - Otherwise load the absolute values, counter=0, go to CALC.
  - If start=0, remain in IDLE.
- CALC:
  - Multiply: shift-add on |a|*|b| into a 64-bit accumulator.
  - Divide: restoring shift-subtract producing |q| and |r|.
  - counter increments every cycle; after the 32nd CALC cycle (counter==31), apply sign fixup, write result, go to DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then go to IDLE with busy=0, done=0.
- Latency:
  - Normal ops: done is high in the 34th cycle counting the accept cycle as 1 (1 accept + 32 CALC + 1 DONE).
  - Fast path: done is high in the 2nd cycle.
- Result selection:
  - MUL: low 32 bits of the product.
  - MULH: high 32 bits, signed x signed.
  - MULHSU: high 32 bits, signed a x unsigned b.
  - MULHU: high 32 bits, unsigned x unsigned.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Signed division: the quotient is negated iff sign(a)!=sign(b); the remainder takes the sign of a (truncating division).
- Fast path for b==0:
  - Quotient = 32'hFFFF_FFFF (DIV and DIVU).
  - Remainder = a (REM and REMU).
- Fast path for signed overflow, a==32'h8000_0000 and b==32'hFFFF_FFFF:
  - DIV = 32'h8000_0000; REM = 0.
- start while busy=1: ignored; the operation in flight is unaffected and no request is queued.
- start asserted in the DONE cycle: ignored; it is accepted on a later edge once busy=0.
- Changes on a, b, or op after the accept edge have no effect.

Optional Feature:
- Macro: MULDIV_ITER_TRACE_EN.
- Defined: on every done pulse, $display "[MULDIV id] op:%0d a:0x%08h b:0x%08h -> 0x%08h"; fast-path completions additionally print "(fast)".
- Undefined: no display statements are compiled; functionally identical.

Decomposition:
- Shared package muldiv_pkg holds:
  - The op localparams OP_MUL..OP_REMU.
  - The state encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
  - MULDIV_CYCLES=32.
- One natural sub-module, muldiv_signfix: combinational conditional two's-complement negate (WIDTH in, negate flag, WIDTH out).
  - Used once for operand absolute values and once for the result fixup.
- The FSM and the datapath stay in muldiv_iter.

Test Plan:
- Reset and idle: hold reset=0 for 2 cycles, then release with start=0 for 5 cycles -> busy=0, done=0, result=0 throughout.
- Multiply: MUL a=7, b=-3 (32'hFFFF_FFFD) -> done in the 34th cycle, result=32'hFFFF_FFEB. MULHU a=b=32'hFFFF_FFFF -> 32'hFFFF_FFFE. MULHSU a=-1, b=2 -> 32'hFFFF_FFFF.
- Divide: DIV a=-7, b=2 -> result=32'hFFFF_FFFD (-3). REM with the same operands -> 32'hFFFF_FFFF (-1). DIVU a=100, b=7 -> 14.
- Fast path: DIVU a=5, b=0 -> 32'hFFFF_FFFF with done in the 2nd cycle. REM a=5, b=0 -> 5. DIV a=32'h8000_0000, b=-1 -> 32'h8000_0000 in the 2nd cycle.
- Handshake: start held high continuously with changing a/b.
  - Exactly one done per 34 cycles.
  - Each result matches the operands present on its accept edge.
  - No done pulses are back-to-back.
- Reset mid-operation: pull reset=0 at CALC cycle 10 -> next cycle busy=0, result=0, and no done pulse ever follows. A new MUL 3x4 afterwards -> 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and the iteration count.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int MULDIV_CYCLES = 32;

   function automatic logic op_a_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_b_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; used for operand magnitudes and
// for restoring the sign of the final result.
module muldiv_signfix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] din,
   input  logic             neg,
   output logic [WIDTH-1:0] dout
);

   assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/muldiv_iter.sv
// Iterative radix-2 RV32M multiply/divide unit with a fast path for
// divide-by-zero and signed overflow. Optional trace: MULDIV_ITER_TRACE_EN.
//
// state   | meaning
// IDLE    | waiting for start; busy=0
// CALC    | 32 shift-add / shift-subtract iterations
// DONE    | done pulse, result valid; returns to IDLE
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int         WIDTH = 32,
   parameter logic [2:0] ID    = 3'b100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(MULDIV_CYCLES);
   localparam logic [CW-1:0] LAST_COUNT = CW'(MULDIV_CYCLES - 1);
   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   state_t state, state_nxt;

   logic [CW-1:0]      counter;
   logic [2:0]         op_q;
   logic               sa_q, sb_q;
   logic [WIDTH-1:0]   opnd;
   logic [2*WIDTH-1:0] acc;

   logic               sa_in, sb_in, fast, fast_ovf, last;
   logic [WIDTH-1:0]   abs_a, abs_b, fast_res, res_fix;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] mul_nxt, div_nxt, acc_nxt, fix_in, fix_out;
   logic               fix_neg;

   assign sa_in    = op_a_signed(op) & a[WIDTH-1];
   assign sb_in    = op_b_signed(op) & b[WIDTH-1];
   assign fast_ovf = ((op == OP_DIV) || (op == OP_REM)) && (a == INT_MIN) && (b == '1);
   assign fast     = op[2] && ((b == '0) || fast_ovf);
   assign last     = (counter == LAST_COUNT);

   muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (.din(a), .neg(sa_in), .dout(abs_a));
   muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (.din(b), .neg(sb_in), .dout(abs_b));

   always_comb begin
      fast_res = '0;
      if (b == '0) begin
         fast_res = op[1] ? a : '1;
      end else begin
         fast_res = op[1] ? '0 : INT_MIN;
      end
   end

   // One iteration of either datapath; acc holds {hi, lo}:
   // multiply {partial product, remaining multiplier}, divide {remainder, quotient}.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_nxt   = {mul_sum, acc[WIDTH-1:1]};
      div_shift = acc[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opnd};
      div_nxt   = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                   acc[WIDTH-2:0], ~div_diff[WIDTH]};
      acc_nxt   = op_q[2] ? div_nxt : mul_nxt;

      fix_in = acc_nxt;
      if (op_q[2]) begin
         fix_in = op_q[1] ? {{WIDTH{1'b0}}, acc_nxt[2*WIDTH-1:WIDTH]}
                          : {{WIDTH{1'b0}}, acc_nxt[WIDTH-1:0]};
      end
      fix_neg = (op_q[2] && op_q[1]) ? sa_q : (sa_q ^ sb_q);
   end

   // Full-width negate so MULH* high halves see the borrow from the low half.
   muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix (.din(fix_in), .neg(fix_neg), .dout(fix_out));

   assign res_fix = ((op_q == OP_MUL) || op_q[2]) ? fix_out[WIDTH-1:0]
                                                  : fix_out[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (start) state_nxt = fast ? ST_DONE : ST_CALC;
         ST_CALC: if (last)  state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         counter <= '0;
         op_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         opnd    <= '0;
         acc     <= '0;
         result  <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  op_q    <= op;
                  sa_q    <= sa_in;
                  sb_q    <= sb_in;
                  counter <= '0;
                  if (fast) begin
                     result <= fast_res;
                  end else begin
                     opnd <= op[2] ? abs_b : abs_a;
                     acc  <= {{WIDTH{1'b0}}, (op[2] ? abs_a : abs_b)};
                  end
               end
            end
            ST_CALC: begin
               acc     <= acc_nxt;
               counter <= counter + CW'(1);
               if (last) result <= res_fix;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

`ifdef MULDIV_ITER_TRACE_EN
   logic [WIDTH-1:0] tr_a, tr_b;
   logic             tr_fast;

   always_ff @(posedge clk) begin
      if (!reset) begin
         tr_a    <= '0;
         tr_b    <= '0;
         tr_fast <= 1'b0;
      end else if ((state == ST_IDLE) && start) begin
         tr_a    <= a;
         tr_b    <= b;
         tr_fast <= fast;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && done) begin
         if (tr_fast)
            $display("[MULDIV %0d] op:%0d a:0x%08h b:0x%08h -> 0x%08h (fast)",
                     ID, op_q, tr_a, tr_b, result);
         else
            $display("[MULDIV %0d] op:%0d a:0x%08h b:0x%08h -> 0x%08h",
                     ID, op_q, tr_a, tr_b, result);
      end
   end
`endif

endmodule

// File: tb/tb_muldiv_iter.sv
// Randomised self-checking bench for muldiv_iter against an arithmetic
// reference model, plus directed literal cases.
module tb_muldiv_iter;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done;
   logic [31:0] result;

   int checks = 0;
   int failures = 0;

   muldiv_iter #(.WIDTH(32), .ID(3'b100)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] xs, ys, yu;
      logic [63:0] xu, p;
      int si, sj;
      xs = {{32{x[31]}}, x};
      ys = {{32{y[31]}}, y};
      yu = {32'b0, y};
      xu = {32'b0, x};
      si = x;
      sj = y;
      case (o)
         OP_MUL:    begin p = xs * ys; return p[31:0];  end
         OP_MULH:   begin p = xs * ys; return p[63:32]; end
         OP_MULHSU: begin p = xs * yu; return p[63:32]; end
         OP_MULHU:  begin p = xu * yu; return p[63:32]; end
         OP_DIV:    if (y == 0) return 32'hFFFF_FFFF;
                    else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                    else return 32'(si / sj);
         OP_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
         OP_REM:    if (y == 0) return x;
                    else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                    else return 32'(si % sj);
         default:   return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic bit is_fast(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      return o[2] && ((y == 0) ||
             (((o == OP_DIV) || (o == OP_REM)) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
   endfunction

   // Cycle-level behavioural model: accept, fixed latency, one-cycle done.
   bit          m_busy = 0, m_done = 0, chk_en = 0;
   logic [31:0] m_result = '0, m_pending = '0;
   int          m_left = 0;

   always @(posedge clk) begin
      if (!reset) begin
         m_busy = 0; m_done = 0; m_result = '0; m_left = 0; chk_en = 1;
      end else if (m_done) begin
         m_done = 0; m_busy = 0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin m_done = 1; m_result = m_pending; end
      end else if (start) begin
         m_busy = 1;
         m_pending = ref_calc(op, a, b);
         if (is_fast(op, a, b)) begin m_done = 1; m_result = m_pending; end
         else m_left = MULDIV_CYCLES;
      end
   end

   bit prev_done = 0;
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy, m_busy);
         check("done", done, m_done);
         check("result", result, m_result);
         check("done_back_to_back", done & prev_done, 0);
         prev_done = done;
      end
   end

   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input int lat, input string name);
      int cyc;
      bit seen;
      check({name, "_model"}, ref_calc(o, x, y), exp);
      @(negedge clk);
      op = o; a = x; b = y; start = 1; cyc = 1; seen = 0;
      while (!seen && cyc < 100) begin
         @(negedge clk);
         cyc++;
         start = 0; op = 3'($urandom); a = $urandom; b = $urandom;
         if (done) seen = 1;
      end
      check({name, "_done_seen"}, seen, 1);
      check({name, "_latency"}, cyc, lat);
      check({name, "_result"}, result, exp);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction

   task automatic wait_idle(input string name);
      int cnt = 0;
      while (busy && cnt < 100) begin @(negedge clk); cnt++; end
      check({name, "_idle_timeout"}, busy, 0);
   endtask

   initial begin
      int cyc, last, nd, cnt;

      // reset and idle
      reset = 0;
      repeat (2) begin
         @(negedge clk);
         check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_result", result, 0);
      end
      reset = 1;
      repeat (5) begin
         @(negedge clk);
         check("idle_busy", busy, 0); check("idle_done", done, 0); check("idle_result", result, 0);
      end

      // directed cases
      run_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7_m3");
      run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_max");
      run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, "mulhsu_m1_2");
      run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div_m7_2");
      run_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "rem_m7_2");
      run_op(OP_DIVU,   32'd100,       32'd7,         32'd14,        34, "divu_100_7");
      run_op(OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 2,  "divu_by0");
      run_op(OP_REM,    32'd5,         32'd0,         32'd5,         2,  "rem_by0");
      run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  "div_ovf");
      run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2,  "rem_ovf");

      // randomised ops, with stray start pulses while busy
      repeat (40) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         @(negedge clk);
         op = 3'($urandom); a = pick(); b = pick(); start = 1;
         cnt = 0;
         while (cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (!busy) break;
            start = 1'($urandom_range(0, 1)); op = 3'($urandom); a = pick(); b = pick();
         end
         start = 0;
         check("rand_idle_timeout", busy, 0);
      end

      // start held high with operands changing every cycle
      @(negedge clk);
      op = 3'($urandom); a = $urandom | 32'h1; b = $urandom | 32'h1; start = 1;
      cyc = 1; last = 0; nd = 0;
      for (int i = 0; i < 209; i++) begin
         @(negedge clk);
         cyc++;
         op = 3'($urandom); a = $urandom; b = $urandom | 32'h1;
         if (a == 32'h8000_0000) a = 32'h1;
         if (done) begin
            nd++;
            if (last != 0) check("hs_gap", cyc - last, 34);
            else check("hs_first_latency", cyc, 34);
            last = cyc;
         end
      end
      start = 0;
      check("hs_done_count", nd, 6);
      wait_idle("hs_drain");

      // reset in the middle of a calculation
      @(negedge clk);
      op = OP_MUL; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1;
      @(negedge clk);
      start = 0;
      repeat (9) @(negedge clk);
      reset = 0;
      @(negedge clk);
      check("midrst_busy", busy, 0); check("midrst_result", result, 0); check("midrst_done", done, 0);
      reset = 1;
      nd = 0;
      repeat (40) begin @(negedge clk); if (done) nd++; end
      check("midrst_no_done", nd, 0);
      run_op(OP_MUL, 32'd3, 32'd4, 32'd12, 34, "mul_3_4_after_rst");

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
